conv_window_fetch: RTL
======================

// Module: conv_window_fetch
// PURPOSE
//  Read-side initiator for the single-port image RAM (w_en/r_en/address/data_in/data_out, 1-cycle registered read).
//  On start, issues WIN*WIN back-to-back reads for one window and returns it as a single parallel word.
//  The read addresses come from a base address and a row stride. The window is held until the convolution datapath accepts it.
//  Sits between the convolution control FSM and the image RAM.
// PARAMETERS
//  ADDR_W  12  RAM address width; all address arithmetic is modulo 2**ADDR_W
//  DATA_W  8   pixel width
//  WIN     3   window edge; element count N = WIN*WIN
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous active-low reset
//  start      in   1            fetch request; sampled only in IDLE; caller holds until busy=1
//  base_addr  in   ADDR_W       address of window element (0,0); sampled with start
//  row_stride in   ADDR_W       address step between window rows; sampled with start
//  busy       out  1            high in every state except IDLE
//  win_valid  out  1            window word valid (HOLD state)
//  win_ready  in   1            consumer accepts; transfer on win_valid & win_ready
//  win_data   out  N*DATA_W     element k=r*WIN+c at [k*DATA_W +: DATA_W]
//  mem_r_en   out  1            RAM read enable
//  mem_w_en   out  1            RAM write enable (constant 0 unless CONV_WRITEBACK_EN)
//  mem_addr   out  ADDR_W       RAM address
//  mem_wdata  out  DATA_W       RAM write data (constant 0 unless CONV_WRITEBACK_EN)
//  mem_rdata  in   DATA_W       RAM data_out, valid the cycle after the r_en edge
// BEHAVIOUR
//  Reset: state IDLE; busy, win_valid, mem_r_en, mem_w_en = 0; mem_addr, mem_wdata, win_data = 0.
//  Mem outputs decode from registered state and counters only; no input-to-output combinational path.
//  FSM states:
//   IDLE  -> ISSUE when start=1. Latches base_addr and row_stride; r=c=0; addr=base.
//   ISSUE -> mem_r_en=1 and mem_addr=addr on every cycle.
//            At each edge: c++, addr++. On c==WIN-1: c=0, r++, row_base+=stride, addr=row_base+stride.
//            After element N-1 is issued, go to DRAIN.
//   DRAIN -> one cycle, mem_r_en=0. Captures the last element. Then HOLD.
//   HOLD  -> win_valid=1; win_data stable. On win_ready, go to IDLE and drop win_valid.
//  Capture: a registered rd_pend flag and index k track the previous-cycle issue.
//   When rd_pend is set, mem_rdata is written into slot k at the next edge.
//  Latency: start accepted at edge E0 -> reads issued E0..E8 -> win_valid=1 from E10 (WIN=3). Total = N+1 edges.
//  Address wrap: addr = (base + r*stride + c) mod 2**ADDR_W. Example: 0xFFF+1 = 0x000. No error is flagged.
//  start while busy: ignored. Request parameters cannot change mid-fetch.
//  win_ready while not HOLD: ignored.
//  Reset mid-fetch: the async clear returns the block to IDLE at once. mem_r_en drops immediately. The partial window is discarded.
//  win_data is not cleared between windows. Slots are overwritten by the next fetch.
// CONFIGURATION
//  CONV_WRITEBACK_EN defined. Adds these ports:
//   wb_valid  in  1
//   wb_ready  out 1       wb_ready = (state==IDLE)
//   wb_addr   in  ADDR_W
//   wb_data   in  DATA_W
//  In IDLE, wb_valid has priority over start. The accepted address/data are latched and the FSM enters WRITE.
//  WRITE: exactly one cycle with mem_w_en=1, mem_addr=wb_addr, mem_wdata=wb_data, mem_r_en=0. Then IDLE.
//  busy=1 during WRITE.
//  CONV_WRITEBACK_EN undefined: no wb_* ports, no WRITE state, mem_w_en=0, mem_wdata=0.
// STRUCTURE
//  Shared package conv_pkg holds:
//   - the state enum (IDLE, ISSUE, DRAIN, HOLD, WRITE)
//   - default ADDR_W/DATA_W/WIN
//   - localparam N = WIN*WIN
//  One sub-module, conv_win_addr_gen: r/c counters, row_base/addr accumulation, last-element flag.
//  The top module keeps the FSM, capture logic, win_data register and writeback path.
// TESTING
//  - RAM preloaded D0,D1,D2,D3,D4,D8,D7,D6,FF at addresses 0..8; base=0, stride=3 ->
//    win_data slots 0..8 = D0,D1,D2,D3,D4,D8,D7,D6,FF. win_valid rises 10 edges after the start edge.
//  - base=0xFFE, stride=0x040 -> issued addresses FFE,FFF,000,03E,03F,040,07E,07F,080 in order, one per cycle, no gaps.
//  - win_ready held 0 for 20 cycles in HOLD -> win_valid and win_data stable, mem_r_en=0, busy=1.
//    Then win_ready=1 for 1 cycle -> IDLE next cycle.
//  - start pulsed again during ISSUE with base=0x100 -> ignored; addresses still follow the original base.
//  - rst_n low after the 4th issue -> mem_r_en=0 and busy=0 immediately.
//    A fresh fetch after release returns a correct full window.
//  - (CONV_WRITEBACK_EN) wb_valid and start both high in IDLE, wb_addr=0x200, wb_data=0x5A ->
//    one cycle w_en=1 @0x200 data 0x5A, then ISSUE. Read-back at 0x200 returns 0x5A.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window fetch slice.
package conv_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_WIN    = 3;
  localparam int unsigned DEF_N      = DEF_WIN * DEF_WIN;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    WRITE = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_fetch_if.sv
// Single-port image RAM bus: initiator drives master, RAM drives slave.
interface conv_window_fetch_if
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_r_en, mem_w_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/conv_win_addr_gen.sv
// Window read address generator: row/column counters with row-base accumulation.
module conv_win_addr_gen
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned WIN    = DEF_WIN,
  localparam int unsigned N     = WIN * WIN,
  localparam int unsigned C_W   = cnt_w(WIN),
  localparam int unsigned K_W   = cnt_w(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic [ADDR_W-1:0] addr,
  output logic [K_W-1:0]    k,
  output logic              last
);

  logic [C_W-1:0]    r_q, c_q;
  logic [K_W-1:0]    k_q;
  logic [ADDR_W-1:0] row_base_q, stride_q, addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
    end else if (load) begin
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      row_base_q <= base_addr;
      stride_q   <= row_stride;
      addr_q     <= base_addr;
    end else if (step) begin
      k_q <= k_q + 1'b1;
      // End of row: jump from the row base rather than the running address.
      if (c_q == C_W'(WIN - 1)) begin
        c_q        <= '0;
        r_q        <= r_q + 1'b1;
        row_base_q <= row_base_q + stride_q;
        addr_q     <= row_base_q + stride_q;
      end else begin
        c_q    <= c_q + 1'b1;
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign addr = addr_q;
  assign k    = k_q;
  assign last = (r_q == C_W'(WIN - 1)) && (c_q == C_W'(WIN - 1));

endmodule

// File: rtl/conv_window_fetch.sv
// Fetches one WIN x WIN window from the image RAM and holds it for the datapath.
// Optional CONV_WRITEBACK_EN adds a single-beat write port that takes priority in IDLE.
module conv_window_fetch
  import conv_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WIN    = DEF_WIN,
  localparam int unsigned N     = WIN * WIN,
  localparam int unsigned K_W   = cnt_w(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   row_stride,
  output logic                busy,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [N*DATA_W-1:0] win_data,
  conv_window_fetch_if.master mem
`ifdef CONV_WRITEBACK_EN
  ,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data
`endif
);

  state_t            state;
  logic              load, step, last;
  logic [ADDR_W-1:0] gen_addr;
  logic [K_W-1:0]    gen_k, rd_k;
  logic              rd_pend;
  logic [N*DATA_W-1:0] win_q;
  logic              wb_take;

`ifdef CONV_WRITEBACK_EN
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  assign wb_take  = (state == IDLE) && wb_valid;
  assign wb_ready = (state == IDLE);
`else
  assign wb_take  = 1'b0;
`endif

  assign load = (state == IDLE) && start && !wb_take;
  assign step = (state == ISSUE);

  conv_win_addr_gen #(
    .ADDR_W (ADDR_W),
    .WIN    (WIN)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .base_addr  (base_addr),
    .row_stride (row_stride),
    .addr       (gen_addr),
    .k          (gen_k),
    .last       (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (wb_take) state <= WRITE;
                 else if (start) state <= ISSUE;
        ISSUE:   if (last) state <= DRAIN;
        DRAIN:   state <= HOLD;
        HOLD:    if (win_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data lags the issue by one cycle, so the slot index is carried along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_k    <= '0;
      win_q   <= '0;
    end else begin
      rd_pend <= step;
      rd_k    <= gen_k;
      if (rd_pend) win_q[rd_k*DATA_W +: DATA_W] <= mem.mem_rdata;
    end
  end

`ifdef CONV_WRITEBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (wb_take) begin
      wb_addr_q <= wb_addr;
      wb_data_q <= wb_data;
    end
  end

  always_comb begin
    mem.mem_w_en  = (state == WRITE);
    mem.mem_wdata = (state == WRITE) ? wb_data_q : '0;
    mem.mem_addr  = '0;
    if (state == ISSUE)      mem.mem_addr = gen_addr;
    else if (state == WRITE) mem.mem_addr = wb_addr_q;
  end
`else
  always_comb begin
    mem.mem_w_en  = 1'b0;
    mem.mem_wdata = '0;
    mem.mem_addr  = (state == ISSUE) ? gen_addr : '0;
  end
`endif

  assign mem.mem_r_en = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign win_valid    = (state == HOLD);
  assign win_data     = win_q;

endmodule
